layer_mask_mac: RTL and testbench
=================================

Name: layer_mask_mac

Overview:
Parametrised successor to the fixed five-lane mask multiply/accumulate stage. It streams LANES signed integer inputs per beat, gated by a binary pixel mask bit. Each input is converted to fixed point, added into per-lane saturating accumulators over a programmed number of beats, and the result vector is presented with a valid/ready handshake. It sits between the input-vector feeder and the activation stage of layer 1.

Parameters:
LANES, 5, number of parallel lanes/neurons
SIZE, 8, width of each signed integer lane input
FRAC_BITS, 4, fixed-point fraction bits; input is shifted left by FRAC_BITS
ACC_SIZE, 16, signed accumulator width per lane; must be >= SIZE+FRAC_BITS+1
COUNT_SIZE, 8, width of beat-length counter
BIPOLAR, 0, 0: mask=0 contributes zero; 1: mask=0 subtracts the term

Ports:
clk  input  1  clock, all flops on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  single-cycle request to begin a new accumulation; honoured only in IDLE
length  input  COUNT_SIZE  number of beats to accumulate; sampled with start
in_valid  input  1  input beat valid
in_ready  output  1  block accepts a beat
vector_input  input  LANES*SIZE  packed signed lane inputs; lane k at [k*SIZE +: SIZE]
mask_input  input  1  mask bit for this beat
out_valid  output  1  result vector valid
out_ready  input  1  downstream accepts result
accumulate_out  output  LANES*ACC_SIZE  packed signed accumulators; lane k at [k*ACC_SIZE +: ACC_SIZE]
overflow  output  LANES  sticky per-lane saturation flag for the current run
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (reset=0, async): state=IDLE; accumulators, overflow, count = 0. in_ready, out_valid and busy deassert immediately. A reset mid-run abandons the run.
- FSM IDLE -> ACCUM -> OUT -> IDLE.
- IDLE: in_ready=0, out_valid=0. On start with length!=0: clear accumulators and overflow, load count=length, go to ACCUM. On start with length==0: clear accumulators and overflow, go directly to OUT.
- ACCUM: in_ready=1. A beat is accepted when in_valid && in_ready. Per accepted beat and lane k: term = sign_extend(x_k, ACC_SIZE) << FRAC_BITS.
  - mask=1: acc += term.
  - mask=0: acc unchanged (BIPOLAR=0) or acc -= term (BIPOLAR=1).
  - Accumulators update on the acceptance edge. Count decrements.
  - Acceptance of the beat with count==1 moves to OUT. in_ready is therefore high for exactly length accepted beats.
  - Cycles with in_valid=0 leave all state unchanged.
- OUT: out_valid=1, in_ready=0. accumulate_out and overflow are held stable until out_ready. On out_valid && out_ready, go to IDLE. The first IDLE cycle has out_valid=0.
- Latency: out_valid rises the cycle after the last beat is accepted.
- Results remain on accumulate_out in IDLE until the next start clears them.
- start is ignored in ACCUM and OUT. start together with out_ready in OUT is also ignored.
- Arithmetic: signed two's complement with saturating add/sub at ACC_SIZE.
  - Positive saturation clamps to 2^(ACC_SIZE-1)-1; negative saturation clamps to -2^(ACC_SIZE-1).
  - Overflow[k] sets on the saturating beat and stays set until the next start or reset.
  - Saturation is computed per beat; later beats may move the accumulator back off the clamp.
- Lanes are fully independent. Lane order in the packed buses is fixed low lane = lane 0.

Test Plan:
1. Defaults; start, length=3; lanes 0..4 = 1,2,3,4,5; masks 1,1,0 -> out_valid one cycle after the third beat; lane0=0x0020, lane4=0x00A0; overflow=0.
2. Lane0=0x80 (-128), mask 1, length=1 -> lane0=0xF800.
3. Lane0=0x7F, mask 1, length=20 -> lane0=0x7F00 after 16 beats, 0x7FFF at beat 17 with overflow[0]=1; final lane0=0x7FFF, overflow[0]=1, other lanes' flags 0.
4. BIPOLAR=1, lane0=3, length=2:
   - masks 1,0 -> lane0=0x0000.
   - masks 0,0 -> lane0=0xFFA0.
5. Handshake and start rules:
   - in_valid gaps of 2 cycles inside a length=4 run -> result equals the gap-free run.
   - out_ready held low 5 cycles -> out_valid and data stable throughout.
   - start pulsed during ACCUM -> ignored.
   - start with length=0 -> out_valid next cycle, all lanes 0.
6. Reset asserted low mid-ACCUM (after 2 of 4 beats) -> in_ready, busy and accumulators 0 immediately, without a clock edge; a new start/length=1 run after release produces a result uncontaminated by the abandoned run.

Source files
------------

// File: rtl/layer_mask_mac_if.sv
// layer_mask_mac_if
//   Groups the control and data handshake of the masked MAC stage.
//   master : the feeder/consumer side (drives start, beats, out_ready)
//   slave  : the MAC stage itself (drives in_ready, results, flags, busy)
//   Signals:
//     start, length             request a run of `length` beats
//     in_valid/in_ready         input beat handshake
//     vector_input, mask_input  packed lane inputs (lane 0 in low bits) + mask
//     out_valid/out_ready       result handshake
//     accumulate_out, overflow  packed accumulators and sticky saturation flags
//     busy                      block is not idle
interface layer_mask_mac_if #(
    parameter int LANES      = 5,
    parameter int SIZE       = 8,
    parameter int ACC_SIZE   = 16,
    parameter int COUNT_SIZE = 8
);
    logic                      start;
    logic [COUNT_SIZE-1:0]     length;
    logic                      in_valid;
    logic                      in_ready;
    logic [LANES*SIZE-1:0]     vector_input;
    logic                      mask_input;
    logic                      out_valid;
    logic                      out_ready;
    logic [LANES*ACC_SIZE-1:0] accumulate_out;
    logic [LANES-1:0]          overflow;
    logic                      busy;

    modport master (
        output start, length, in_valid, vector_input, mask_input, out_ready,
        input  in_ready, out_valid, accumulate_out, overflow, busy
    );

    modport slave (
        input  start, length, in_valid, vector_input, mask_input, out_ready,
        output in_ready, out_valid, accumulate_out, overflow, busy
    );
endinterface

// File: rtl/layer_mask_mac.sv
// layer_mask_mac
//   Masked multiply/accumulate stage for layer 1. Each accepted beat adds
//   (or, in bipolar mode with mask=0, subtracts) every lane input, scaled to
//   fixed point by FRAC_BITS, into a per-lane saturating accumulator. After
//   `length` beats the result vector is offered on a valid/ready handshake.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-low reset
//     bus    layer_mask_mac_if.slave (start/length, input beats, results)
//   The interface instance must be parameterised with the same LANES, SIZE,
//   ACC_SIZE and COUNT_SIZE as this module.
module layer_mask_mac #(
    parameter int LANES      = 5,
    parameter int SIZE       = 8,
    parameter int FRAC_BITS  = 4,
    parameter int ACC_SIZE   = 16,
    parameter int COUNT_SIZE = 8,
    parameter int BIPOLAR    = 0
) (
    input  logic            clk,
    input  logic            reset,
    layer_mask_mac_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } state_t;

    localparam logic [ACC_SIZE-1:0] ACC_MAX = {1'b0, {(ACC_SIZE-1){1'b1}}};
    localparam logic [ACC_SIZE-1:0] ACC_MIN = {1'b1, {(ACC_SIZE-1){1'b0}}};

    state_t                          state_reg, state_next;
    logic [COUNT_SIZE-1:0]           count_reg, count_next;
    logic [LANES-1:0][ACC_SIZE-1:0]  acc_reg;
    logic [LANES-1:0][ACC_SIZE-1:0]  acc_sat;
    logic [LANES-1:0]                ovf_reg;
    logic [LANES-1:0]                sat_ovf;
    logic                            clear;
    logic                            accept;

    // Control FSM: next state, counter and handshake outputs.
    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        clear        = 1'b0;
        accept       = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = (state_reg != IDLE);
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    clear = 1'b1;
                    if (bus.length != '0) begin
                        count_next = bus.length;
                        state_next = ACCUM;
                    end else begin
                        state_next = OUT;
                    end
                end
            end
            ACCUM: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept     = 1'b1;
                    count_next = count_reg - COUNT_SIZE'(1);
                    if (count_reg == COUNT_SIZE'(1)) begin
                        state_next = OUT;
                    end
                end
            end
            OUT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    // Per-lane saturating add/subtract. The sum is formed one bit wider than
    // the accumulator so a sign disagreement between the top two bits flags
    // overflow and picks the clamp direction.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [SIZE-1:0]     x_raw;
        logic [ACC_SIZE-1:0] term;
        logic [ACC_SIZE:0]   sum;

        assign x_raw = bus.vector_input[gi*SIZE +: SIZE];
        assign term  = {{(ACC_SIZE-SIZE){x_raw[SIZE-1]}}, x_raw} << FRAC_BITS;

        always_comb begin
            sum = {acc_reg[gi][ACC_SIZE-1], acc_reg[gi]};
            if (bus.mask_input) begin
                sum = sum + {term[ACC_SIZE-1], term};
            end else if (BIPOLAR != 0) begin
                sum = sum - {term[ACC_SIZE-1], term};
            end
        end

        assign sat_ovf[gi] = sum[ACC_SIZE] ^ sum[ACC_SIZE-1];
        assign acc_sat[gi] = !sat_ovf[gi] ? sum[ACC_SIZE-1:0]
                           : (sum[ACC_SIZE] ? ACC_MIN : ACC_MAX);
    end

    // Accumulators and sticky flags; results stay visible in IDLE until the
    // next start clears them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_reg <= '0;
            ovf_reg <= '0;
        end else if (clear) begin
            acc_reg <= '0;
            ovf_reg <= '0;
        end else if (accept) begin
            acc_reg <= acc_sat;
            ovf_reg <= ovf_reg | sat_ovf;
        end
    end

    assign bus.accumulate_out = acc_reg;
    assign bus.overflow       = ovf_reg;
endmodule

// File: tb/tb_layer_mask_mac.sv
// tb_layer_mask_mac
//   Drives a unipolar (dut0) and a bipolar (dut1) instance with identical
//   stimulus and compares both against an integer reference model.
module tb_layer_mask_mac;
    localparam int LANES      = 5;
    localparam int SIZE       = 8;
    localparam int FRAC_BITS  = 4;
    localparam int ACC_SIZE   = 16;
    localparam int COUNT_SIZE = 8;
    localparam int AMAX       = 32767;
    localparam int AMIN       = -32768;
    localparam int VW         = LANES*SIZE;
    localparam int AW         = LANES*ACC_SIZE;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic                  start_s     = 1'b0;
    logic [COUNT_SIZE-1:0] length_s    = '0;
    logic                  in_valid_s  = 1'b0;
    logic [VW-1:0]         vec_s       = '0;
    logic                  mask_s      = 1'b0;
    logic                  out_ready_s = 1'b0;

    layer_mask_mac_if #(.LANES(LANES), .SIZE(SIZE), .ACC_SIZE(ACC_SIZE), .COUNT_SIZE(COUNT_SIZE)) if0 ();
    layer_mask_mac_if #(.LANES(LANES), .SIZE(SIZE), .ACC_SIZE(ACC_SIZE), .COUNT_SIZE(COUNT_SIZE)) if1 ();

    assign if0.start = start_s;        assign if1.start = start_s;
    assign if0.length = length_s;      assign if1.length = length_s;
    assign if0.in_valid = in_valid_s;  assign if1.in_valid = in_valid_s;
    assign if0.vector_input = vec_s;   assign if1.vector_input = vec_s;
    assign if0.mask_input = mask_s;    assign if1.mask_input = mask_s;
    assign if0.out_ready = out_ready_s; assign if1.out_ready = out_ready_s;

    layer_mask_mac #(.LANES(LANES), .SIZE(SIZE), .FRAC_BITS(FRAC_BITS), .ACC_SIZE(ACC_SIZE),
                     .COUNT_SIZE(COUNT_SIZE), .BIPOLAR(0)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    layer_mask_mac #(.LANES(LANES), .SIZE(SIZE), .FRAC_BITS(FRAC_BITS), .ACC_SIZE(ACC_SIZE),
                     .COUNT_SIZE(COUNT_SIZE), .BIPOLAR(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));

    int tests = 0;
    int fails = 0;

    logic [VW-1:0]    beat_vec [64];
    logic             beat_m   [64];
    logic [AW-1:0]    exp0, exp1;
    logic [LANES-1:0] eovf0, eovf1;

    logic             lat0, lat1, post_valid, post_busy;
    logic [AW-1:0]    cap0, cap1, post_acc0;
    logic [LANES-1:0] covf0, covf1;
    int               hold_bad;

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int k = 0; k < LANES; k++) v[k*SIZE +: SIZE] = 8'($urandom);
        return v;
    endfunction

    // Reference: integer accumulate with clamping after every beat.
    task automatic compute(input int n);
        int a, x, t;
        bit o;
        for (int k = 0; k < LANES; k++) begin
            for (int bip = 0; bip < 2; bip++) begin
                a = 0;
                o = 1'b0;
                for (int b = 0; b < n; b++) begin
                    x = $signed(beat_vec[b][k*SIZE +: SIZE]);
                    t = x * (1 << FRAC_BITS);
                    if (beat_m[b]) a = a + t;
                    else if (bip == 1) a = a - t;
                    if (a > AMAX) begin a = AMAX; o = 1'b1; end
                    else if (a < AMIN) begin a = AMIN; o = 1'b1; end
                end
                if (bip == 0) begin exp0[k*ACC_SIZE +: ACC_SIZE] = a[15:0]; eovf0[k] = o; end
                else          begin exp1[k*ACC_SIZE +: ACC_SIZE] = a[15:0]; eovf1[k] = o; end
            end
        end
    endtask

    // Runs one job: start, n beats with optional invalid gaps, result held for
    // `hold` cycles, then handshake. poke pulses start while busy.
    task automatic run_job(input int n, input int gap, input int hold, input bit poke);
        int guard;
        hold_bad = 0;
        @(negedge clk);
        start_s = 1'b1;
        length_s = n[COUNT_SIZE-1:0];
        @(negedge clk);
        start_s = 1'b0;
        for (int b = 0; b < n; b++) begin
            if (b > 0) begin
                for (int g = 0; g < gap; g++) begin
                    in_valid_s = 1'b0;
                    vec_s = rand_vec();
                    mask_s = 1'($urandom);
                    start_s = poke && (g == 0);
                    length_s = 8'd7;
                    @(negedge clk);
                    start_s = 1'b0;
                end
            end
            in_valid_s = 1'b1;
            vec_s = beat_vec[b];
            mask_s = beat_m[b];
            guard = 0;
            while (if0.in_ready !== 1'b1 && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 50) begin
                tests++; fails++;
                $display("FAIL timeout_in_ready beat %0d: in_ready=%b, required 1 within 50 cycles", b, if0.in_ready);
            end
            @(negedge clk);
        end
        in_valid_s = 1'b0;
        vec_s = rand_vec();
        lat0 = if0.out_valid;  lat1 = if1.out_valid;
        cap0 = if0.accumulate_out; cap1 = if1.accumulate_out;
        covf0 = if0.overflow;  covf1 = if1.overflow;
        for (int h = 0; h < hold; h++) begin
            start_s = poke && (h == 0);
            length_s = 8'd7;
            if (if0.out_valid !== 1'b1 || if1.out_valid !== 1'b1 ||
                if0.accumulate_out !== exp0 || if1.accumulate_out !== exp1 ||
                if0.overflow !== eovf0 || if1.overflow !== eovf1) hold_bad++;
            @(negedge clk);
            start_s = 1'b0;
        end
        out_ready_s = 1'b1;
        start_s = poke;
        @(negedge clk);
        out_ready_s = 1'b0;
        start_s = 1'b0;
        post_valid = if0.out_valid | if1.out_valid;
        post_busy  = if0.busy | if1.busy;
        post_acc0  = if0.accumulate_out;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({if0.in_ready, if0.out_valid, if0.busy, if1.in_ready, if1.out_valid, if1.busy} !== 6'b0) begin
            fails++;
            $display("FAIL reset_ctrl got %b%b%b %b%b%b, required all 0", if0.in_ready, if0.out_valid,
                     if0.busy, if1.in_ready, if1.out_valid, if1.busy);
        end
        tests++;
        if (if0.accumulate_out !== '0 || if1.accumulate_out !== '0 || if0.overflow !== '0 || if1.overflow !== '0) begin
            fails++;
            $display("FAIL reset_data acc0=%h acc1=%h ovf0=%b ovf1=%b, required 0", if0.accumulate_out,
                     if1.accumulate_out, if0.overflow, if1.overflow);
        end
        reset = 1'b1;
        @(negedge clk);
        $display("[TB] reset checked");
    endtask

    task automatic test_basic();
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < LANES; k++) beat_vec[b][k*SIZE +: SIZE] = 8'(k + 1);
            beat_m[b] = (b < 2);
        end
        compute(3);
        run_job(3, 0, 0, 1'b0);
        tests++;
        if (lat0 !== 1'b1 || lat1 !== 1'b1) begin fails++; $display("FAIL basic_latency out_valid=%b/%b, required 1", lat0, lat1); end
        tests++;
        if (cap0[15:0] !== 16'h0020 || cap0[79:64] !== 16'h00A0 || covf0 !== 5'b0) begin
            fails++; $display("FAIL basic_lanes lane0=%h lane4=%h ovf=%b, required 0020 00a0 0", cap0[15:0], cap0[79:64], covf0);
        end
        tests++;
        if (cap0 !== exp0 || cap1 !== exp1) begin fails++; $display("FAIL basic_model acc0=%h acc1=%h, required %h %h", cap0, cap1, exp0, exp1); end
        tests++;
        if (post_valid !== 1'b0 || post_busy !== 1'b0 || post_acc0 !== exp0) begin
            fails++; $display("FAIL basic_idle valid=%b busy=%b acc=%h, required 0 0 %h", post_valid, post_busy, post_acc0, exp0);
        end
        $display("[TB] basic run: lane0=%h lane4=%h", cap0[15:0], cap0[79:64]);
    endtask

    task automatic test_negative();
        beat_vec[0] = '0;
        beat_vec[0][7:0] = 8'h80;
        beat_m[0] = 1'b1;
        compute(1);
        run_job(1, 0, 0, 1'b0);
        tests++;
        if (cap0[15:0] !== 16'hF800 || cap0 !== exp0 || cap1 !== exp1) begin
            fails++; $display("FAIL negative lane0=%h acc1=%h, required f800 %h", cap0[15:0], cap1, exp1);
        end
        $display("[TB] negative run: lane0=%h", cap0[15:0]);
    endtask

    task automatic test_saturation();
        int lens [3] = '{16, 17, 20};
        logic [15:0] want [3] = '{16'h7F00, 16'h7FFF, 16'h7FFF};
        for (int r = 0; r < 3; r++) begin
            for (int b = 0; b < lens[r]; b++) begin
                for (int k = 1; k < LANES; k++) beat_vec[b][k*SIZE +: SIZE] = 8'($urandom_range(0, 15) - 8);
                beat_vec[b][7:0] = 8'h7F;
                beat_m[b] = 1'b1;
            end
            compute(lens[r]);
            run_job(lens[r], 0, 0, 1'b0);
            tests++;
            if (cap0[15:0] !== want[r] || covf0 !== {4'b0, (r > 0)}) begin
                fails++; $display("FAIL sat_len%0d lane0=%h ovf=%b, required %h %b", lens[r], cap0[15:0], covf0, want[r], {4'b0, (r > 0)});
            end
            tests++;
            if (cap0 !== exp0 || cap1 !== exp1 || covf0 !== eovf0 || covf1 !== eovf1) begin
                fails++; $display("FAIL sat_model_len%0d acc0=%h acc1=%h ovf=%b/%b, required %h %h %b/%b", lens[r],
                                  cap0, cap1, covf0, covf1, exp0, exp1, eovf0, eovf1);
            end
            $display("[TB] saturation length=%0d: lane0=%h ovf=%b", lens[r], cap0[15:0], covf0);
        end
    endtask

    task automatic test_bipolar();
        logic [15:0] want [2] = '{16'h0000, 16'hFFA0};
        for (int r = 0; r < 2; r++) begin
            beat_vec[0] = '0; beat_vec[1] = '0;
            beat_vec[0][7:0] = 8'd3; beat_vec[1][7:0] = 8'd3;
            beat_m[0] = (r == 0); beat_m[1] = 1'b0;
            compute(2);
            run_job(2, 0, 0, 1'b0);
            tests++;
            if (cap1[15:0] !== want[r] || cap1 !== exp1 || cap0 !== exp0) begin
                fails++; $display("FAIL bipolar_%0d lane0=%h acc0=%h, required %h %h", r, cap1[15:0], cap0, want[r], exp0);
            end
            $display("[TB] bipolar case %0d: lane0=%h", r, cap1[15:0]);
        end
    endtask

    task automatic test_gaps_hold_start();
        for (int b = 0; b < 4; b++) begin beat_vec[b] = rand_vec(); beat_m[b] = 1'($urandom); end
        compute(4);
        run_job(4, 0, 0, 1'b0);
        tests++;
        if (cap0 !== exp0 || cap1 !== exp1) begin fails++; $display("FAIL nogap acc0=%h acc1=%h, required %h %h", cap0, cap1, exp0, exp1); end
        run_job(4, 2, 5, 1'b1);
        tests++;
        if (lat0 !== 1'b1 || cap0 !== exp0 || cap1 !== exp1) begin
            fails++; $display("FAIL gap_run valid=%b acc0=%h acc1=%h, required 1 %h %h", lat0, cap0, cap1, exp0, exp1);
        end
        tests++;
        if (hold_bad !== 0) begin fails++; $display("FAIL hold_stable unstable cycles=%0d, required 0", hold_bad); end
        tests++;
        if (post_valid !== 1'b0 || post_busy !== 1'b0) begin
            fails++; $display("FAIL start_ignored valid=%b busy=%b after handshake, required 0 0", post_valid, post_busy);
        end
        $display("[TB] gap/hold/start run: acc0=%h hold_bad=%0d", cap0, hold_bad);
    endtask

    task automatic test_zero_length();
        compute(0);
        run_job(0, 0, 1, 1'b0);
        tests++;
        if (lat0 !== 1'b1 || lat1 !== 1'b1 || cap0 !== '0 || cap1 !== '0 || covf0 !== '0) begin
            fails++; $display("FAIL zero_length valid=%b/%b acc0=%h acc1=%h ovf=%b, required 1 1 0 0 0", lat0, lat1, cap0, cap1, covf0);
        end
        $display("[TB] zero-length run: valid=%b acc0=%h", lat0, cap0);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start_s = 1'b1; length_s = 8'd4;
        @(negedge clk);
        start_s = 1'b0;
        for (int b = 0; b < 2; b++) begin
            in_valid_s = 1'b1;
            vec_s = {LANES{8'd5}};
            mask_s = 1'b1;
            @(negedge clk);
        end
        in_valid_s = 1'b0;
        #2 reset = 1'b0;
        #1;
        tests++;
        if (if0.in_ready !== 1'b0 || if0.busy !== 1'b0 || if1.busy !== 1'b0 ||
            if0.accumulate_out !== '0 || if1.accumulate_out !== '0) begin
            fails++; $display("FAIL reset_mid ready=%b busy=%b/%b acc0=%h acc1=%h, required 0 0/0 0 0",
                              if0.in_ready, if0.busy, if1.busy, if0.accumulate_out, if1.accumulate_out);
        end
        @(negedge clk);
        reset = 1'b1;
        beat_vec[0] = rand_vec(); beat_m[0] = 1'b1;
        compute(1);
        run_job(1, 0, 0, 1'b0);
        tests++;
        if (cap0 !== exp0 || cap1 !== exp1) begin fails++; $display("FAIL after_reset acc0=%h acc1=%h, required %h %h", cap0, cap1, exp0, exp1); end
        $display("[TB] mid-run reset then length=1: acc0=%h", cap0);
    endtask

    task automatic test_random();
        int n, gap, hold;
        bit poke;
        for (int it = 0; it < 10; it++) begin
            n = $urandom_range(1, 24);
            gap = $urandom_range(0, 2);
            hold = $urandom_range(0, 3);
            poke = 1'($urandom);
            for (int b = 0; b < n; b++) begin beat_vec[b] = rand_vec(); beat_m[b] = 1'($urandom); end
            compute(n);
            run_job(n, gap, hold, poke);
            tests++;
            if (lat0 !== 1'b1 || cap0 !== exp0 || covf0 !== eovf0) begin
                fails++; $display("FAIL rand%0d_uni valid=%b acc=%h ovf=%b, required 1 %h %b", it, lat0, cap0, covf0, exp0, eovf0);
            end
            tests++;
            if (lat1 !== 1'b1 || cap1 !== exp1 || covf1 !== eovf1) begin
                fails++; $display("FAIL rand%0d_bip valid=%b acc=%h ovf=%b, required 1 %h %b", it, lat1, cap1, covf1, exp1, eovf1);
            end
            tests++;
            if (hold_bad !== 0 || post_valid !== 1'b0 || post_busy !== 1'b0) begin
                fails++; $display("FAIL rand%0d_hs hold_bad=%0d valid=%b busy=%b, required 0 0 0", it, hold_bad, post_valid, post_busy);
            end
            $display("[TB] random run %0d: n=%0d gap=%0d hold=%0d acc0=%h", it, n, gap, hold, cap0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_saturation();
        test_bipolar();
        test_gaps_hold_start();
        test_zero_length();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
